// File: rtl/sim_testutil_ctrl.sv
// sim_testutil_ctrl
// Simulation test controller. Software programs a signature region through the
// device port and then writes HALT with an exit code. The block streams the
// region out through a pipelined host read port with up to MaxOutstanding reads
// in flight, presents every returned word on the monitor port, then raises done_o.
//
// Optional feature macro: SIM_TESTUTIL_FINISH_EN
//   defined   : each signature word is printed and the run ends with $finish on DONE
//   undefined : nothing is printed, the run is not terminated
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   dev_req_i/we/addr/wdata/be   device access (always accepted)
//   dev_rvalid_o/rdata_o/err_o   device response, one cycle after the request
//   host_req_o/gnt_i/addr_o      host read request channel
//   host_rvalid_i/rdata_i        host read response channel (in order)
//   sig_valid_o/data_o/index_o   one strobe per signature word
//   done_o, exit_code_o          sticky completion flag and latched exit code
module sim_testutil_ctrl #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned CountWidth     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dev_req_i,
  input  logic                  dev_we_i,
  input  logic [31:0]           dev_addr_i,
  input  logic [31:0]           dev_wdata_i,
  input  logic [3:0]            dev_be_i,
  output logic                  dev_rvalid_o,
  output logic [31:0]           dev_rdata_o,
  output logic                  dev_err_o,
  output logic                  host_req_o,
  input  logic                  host_gnt_i,
  output logic [31:0]           host_addr_o,
  input  logic                  host_rvalid_i,
  input  logic [31:0]           host_rdata_i,
  output logic                  sig_valid_o,
  output logic [31:0]           sig_data_o,
  output logic [CountWidth-1:0] sig_index_o,
  output logic                  done_o,
  output logic [31:0]           exit_code_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [9:0] OffHalt   = 10'h000;
  localparam logic [9:0] OffBegin  = 10'h004;
  localparam logic [9:0] OffEnd    = 10'h008;
  localparam logic [9:0] OffStatus = 10'h00C;
  localparam logic [3:0] MaxOut    = 4'(MaxOutstanding);

  state_e                state_r, state_s;
  logic [31:0]           begin_r, end_r, addr_r, addr_s, exit_code_r;
  logic [3:0]            outstanding_r, outstanding_s;
  logic [CountWidth-1:0] count_r, count_s;
  logic                  host_req_r;
  logic                  dev_rvalid_r, dev_err_r, dev_err_s;
  logic [31:0]           dev_rdata_r, dev_rdata_s;
  logic                  sig_valid_r, done_r;
  logic [31:0]           sig_data_r;
  logic [CountWidth-1:0] sig_index_r;
  logic                  halt_wr_s, begin_wr_s, end_wr_s;
  logic                  busy_s, region_ok_s, host_fire_s, rsp_take_s;
  logic [9:0]            dev_off_s;
  logic [31:0]           cnt_ext_s, status_s;
  logic                  unused_s;

  assign dev_off_s   = dev_addr_i[9:0];
  assign busy_s      = (state_r == ST_ISSUE) || (state_r == ST_DRAIN);
  assign region_ok_s = (begin_r[1:0] == 2'd0) && (end_r[1:0] == 2'd0) && (end_r >= begin_r);
  assign host_fire_s = host_req_r && host_gnt_i;
  // Responses only count while a read is actually in flight for this dump.
  assign rsp_take_s  = host_rvalid_i && (outstanding_r != 4'd0) && busy_s;
  assign cnt_ext_s   = 32'(count_r);
  assign status_s    = {cnt_ext_s[15:0], 14'd0, done_r, busy_s};
  assign unused_s    = ^{dev_addr_i[31:10], cnt_ext_s[31:16]};

  // Device register decode: read data, error detection and write strobes.
  always_comb begin
    dev_err_s   = 1'b0;
    dev_rdata_s = 32'd0;
    halt_wr_s   = 1'b0;
    begin_wr_s  = 1'b0;
    end_wr_s    = 1'b0;
    if (dev_req_i) begin
      if (dev_we_i && (dev_be_i != 4'hF)) begin
        dev_err_s = 1'b1;
      end else begin
        case (dev_off_s)
          OffHalt: begin
            if (!dev_we_i || (state_r != ST_IDLE) || !region_ok_s) dev_err_s = 1'b1;
            else                                                   halt_wr_s = 1'b1;
          end
          OffBegin: begin
            if (!dev_we_i)   dev_rdata_s = begin_r;
            else if (busy_s) dev_err_s   = 1'b1;
            else             begin_wr_s  = 1'b1;
          end
          OffEnd: begin
            if (!dev_we_i)   dev_rdata_s = end_r;
            else if (busy_s) dev_err_s   = 1'b1;
            else             end_wr_s    = 1'b1;
          end
          OffStatus: begin
            if (dev_we_i) dev_err_s   = 1'b1;
            else          dev_rdata_s = status_s;
          end
          default: dev_err_s = 1'b1;
        endcase
      end
    end else begin
      dev_err_s = 1'b0;
    end
  end

  // Next-state logic of the dump sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (halt_wr_s) state_s = (begin_r == end_r) ? ST_DONE : ST_ISSUE;
        else           state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (host_fire_s && ((addr_r + 32'd4) == end_r)) state_s = ST_DRAIN;
        else                                           state_s = ST_ISSUE;
      end
      ST_DRAIN: begin
        if (outstanding_r == 4'd0) state_s = ST_DONE;
        else                       state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_DONE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Dump datapath: next read address, in-flight count and word counter.
  always_comb begin
    addr_s        = addr_r;
    outstanding_s = outstanding_r;
    count_s       = count_r;
    if (halt_wr_s) begin
      addr_s        = begin_r;
      outstanding_s = 4'd0;
      count_s       = {CountWidth{1'b0}};
    end else begin
      if (host_fire_s) addr_s = addr_r + 32'd4;
      else             addr_s = addr_r;
      // A grant and a response in the same cycle cancel out.
      case ({host_fire_s, rsp_take_s})
        2'b10:   outstanding_s = outstanding_r + 4'd1;
        2'b01:   outstanding_s = outstanding_r - 4'd1;
        default: outstanding_s = outstanding_r;
      endcase
      if (rsp_take_s) count_s = count_r + CountWidth'(1);
      else            count_s = count_r;
    end
  end

  // Sequencer state, dump counters, host request and monitor outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r       <= ST_IDLE;
      addr_r        <= 32'd0;
      outstanding_r <= 4'd0;
      count_r       <= {CountWidth{1'b0}};
      host_req_r    <= 1'b0;
      sig_valid_r   <= 1'b0;
      sig_data_r    <= 32'd0;
      sig_index_r   <= {CountWidth{1'b0}};
      done_r        <= 1'b0;
      exit_code_r   <= 32'd0;
    end else begin
      state_r       <= state_s;
      addr_r        <= addr_s;
      outstanding_r <= outstanding_s;
      count_r       <= count_s;
      // Registered request: computed from the state and count of the next cycle.
      host_req_r    <= (state_s == ST_ISSUE) && (outstanding_s < MaxOut);
      sig_valid_r   <= rsp_take_s;
      if (rsp_take_s) begin
        sig_data_r  <= host_rdata_i;
        sig_index_r <= count_r;
      end
      done_r        <= (state_s == ST_DONE);
      if (halt_wr_s) exit_code_r <= dev_wdata_i;
    end
  end

  // Region registers and the registered device response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      begin_r      <= 32'd0;
      end_r        <= 32'd0;
      dev_rvalid_r <= 1'b0;
      dev_rdata_r  <= 32'd0;
      dev_err_r    <= 1'b0;
    end else begin
      if (begin_wr_s) begin_r <= dev_wdata_i;
      if (end_wr_s)   end_r   <= dev_wdata_i;
      dev_rvalid_r <= dev_req_i;
      dev_rdata_r  <= dev_rdata_s;
      dev_err_r    <= dev_err_s;
    end
  end

`ifdef SIM_TESTUTIL_FINISH_EN
  // Report signature words and end the simulation once the dump completes.
  always @(posedge clk_i) begin
    if (sig_valid_r) begin
      $display("SIGNATURE: 0x%08x", sig_data_r);
    end
    if (done_r) begin
      $display("EXIT CODE: 0x%08x", exit_code_r);
      $finish;
    end
  end
`else
  // Silent build: completion is visible only through done_o and exit_code_o.
`endif

  assign dev_rvalid_o = dev_rvalid_r;
  assign dev_rdata_o  = dev_rdata_r;
  assign dev_err_o    = dev_err_r;
  assign host_req_o   = host_req_r;
  assign host_addr_o  = addr_r;
  assign sig_valid_o  = sig_valid_r;
  assign sig_data_o   = sig_data_r;
  assign sig_index_o  = sig_index_r;
  assign done_o       = done_r;
  assign exit_code_o  = exit_code_r;

endmodule

// File: tb/tb_sim_testutil_ctrl.sv
module tb_sim_testutil_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dev_req_i, dev_we_i;
  logic [31:0] dev_addr_i, dev_wdata_i;
  logic [3:0]  dev_be_i;
  logic        dev_rvalid_o, dev_err_o;
  logic [31:0] dev_rdata_o;
  logic        host_req_o, host_gnt_i, host_rvalid_i;
  logic [31:0] host_addr_o, host_rdata_i;
  logic        sig_valid_o, done_o;
  logic [31:0] sig_data_o, exit_code_o;
  logic [15:0] sig_index_o;

  sim_testutil_ctrl #(.MaxOutstanding(2), .CountWidth(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dev_req_i(dev_req_i), .dev_we_i(dev_we_i), .dev_addr_i(dev_addr_i),
    .dev_wdata_i(dev_wdata_i), .dev_be_i(dev_be_i),
    .dev_rvalid_o(dev_rvalid_o), .dev_rdata_o(dev_rdata_o), .dev_err_o(dev_err_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_addr_o(host_addr_o),
    .host_rvalid_i(host_rvalid_i), .host_rdata_i(host_rdata_i),
    .sig_valid_o(sig_valid_o), .sig_data_o(sig_data_o), .sig_index_o(sig_index_o),
    .done_o(done_o), .exit_code_o(exit_code_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // memory / monitor state
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pend_q[$];
  logic [31:0] grant_addr_q[$];
  int          grant_cyc_q[$];
  int          rv_cyc_q[$];
  logic [31:0] sig_data_q[$];
  logic [15:0] sig_idx_q[$];
  int          sig_cyc_q[$];
  int          cyc = 0;
  int          done_cyc = -1;
  int          lat = 1;
  logic        gnt_en = 1'b1;
  logic        stray = 1'b0;
  int          mdl_out = 0;
  int          mdl_max = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[20];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08x expected 0x%08x", name, act, exp);
    end
  endtask

  // Memory responder and output monitor, all on the falling edge.
  initial begin
    forever begin
      logic        rv_l;
      logic [31:0] rd_l;
      int          gr_l;
      int          tk_l;
      @(negedge clk_i);
      cyc++;
      if (sig_valid_o) begin
        sig_data_q.push_back(sig_data_o);
        sig_idx_q.push_back(sig_index_o);
        sig_cyc_q.push_back(cyc);
      end
      if (done_o && done_cyc < 0) done_cyc = cyc;
      rv_l = 1'b0;
      rd_l = 32'd0;
      tk_l = 0;
      gr_l = 0;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        rv_l = 1'b1;
        rd_l = mem_data(pend_q[0].addr);
        pend_q.pop_front();
        rv_cyc_q.push_back(cyc);
        if (mdl_out > 0) tk_l = 1;
      end
      if (stray) begin
        rv_l = 1'b1;
        rd_l = 32'hDEAD_BEEF;
      end
      host_rvalid_i = rv_l;
      host_rdata_i  = rd_l;
      host_gnt_i    = gnt_en;
      if (host_req_o && gnt_en) begin
        grant_addr_q.push_back(host_addr_o);
        grant_cyc_q.push_back(cyc);
        pend_q.push_back('{host_addr_o, cyc + lat});
        gr_l = 1;
      end
      if (rst_i) mdl_out = 0;
      else       mdl_out = mdl_out + gr_l - tk_l;
      if (mdl_out > mdl_max) mdl_max = mdl_out;
    end
  end

  task automatic clear_logs();
    grant_addr_q.delete();
    grant_cyc_q.delete();
    rv_cyc_q.delete();
    sig_data_q.delete();
    sig_idx_q.delete();
    sig_cyc_q.delete();
    done_cyc = -1;
    mdl_max  = 0;
  endtask

  task automatic dev_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] rdata, output logic err);
    @(negedge clk_i);
    dev_req_i   = 1'b1;
    dev_we_i    = we;
    dev_addr_i  = addr;
    dev_wdata_i = wdata;
    dev_be_i    = be;
    @(negedge clk_i);
    check("dev_rvalid", {31'd0, dev_rvalid_o}, 32'd1);
    rdata       = dev_rdata_o;
    err         = dev_err_o;
    dev_req_i   = 1'b0;
    dev_we_i    = 1'b0;
    dev_addr_i  = 32'd0;
    dev_wdata_i = 32'd0;
    dev_be_i    = 4'h0;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {31'd0, |{host_req_o, host_addr_o, sig_valid_o, sig_data_o, sig_index_o,
                          done_o, exit_code_o, dev_rvalid_o, dev_rdata_o, dev_err_o}}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check_outputs_zero("reset_outputs");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done_o && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    check("done_wait", {31'd0, done_o}, 32'd1);
  endtask

  task automatic check_words(input string tag, input int n, input logic [31:0] base);
    check({tag, "_count"}, sig_data_q.size(), n);
    for (int i = 0; i < n && i < sig_data_q.size(); i++) begin
      check({tag, "_index"}, {16'd0, sig_idx_q[i]}, i);
      check({tag, "_data"}, sig_data_q[i], mem_data(base + 32'(4 * i)));
    end
  endtask

  task automatic program_region(input logic [31:0] b, input logic [31:0] e);
    logic [31:0] rd;
    logic        er;
    dev_access(1'b1, 32'h004, b, 4'hF, rd, er);
    check("prog_begin_err", {31'd0, er}, 32'd0);
    dev_access(1'b1, 32'h008, e, 4'hF, rd, er);
    check("prog_end_err", {31'd0, er}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    rst_i = 1'b1;
    dev_req_i = 1'b0; dev_we_i = 1'b0; dev_addr_i = 32'd0; dev_wdata_i = 32'd0; dev_be_i = 4'h0;
    host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_rdata_i = 32'd0;

    vecs[0]  = '{1'b0, 32'h0000_0004, 32'h0,      4'hF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0004, 32'h1000,   4'hF, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'hFFFF_F004, 32'h0,      4'hF, 1'b0, 32'h1000};
    vecs[3]  = '{1'b1, 32'h0000_0008, 32'h1010,   4'h3, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,      4'hF, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 32'h0000_0008, 32'h1010,   4'hF, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 32'h0000_0008, 32'h0,      4'hF, 1'b0, 32'h1010};
    vecs[7]  = '{1'b1, 32'h0000_0010, 32'h1,      4'hF, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_03FC, 32'h0,      4'hF, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 32'h0000_000C, 32'h3,      4'hF, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,      4'hF, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 32'h0000_000C, 32'h0,      4'hF, 1'b0, 32'h0};
    vecs[12] = '{1'b1, 32'h0000_0004, 32'h1002,   4'hF, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 32'h0000_0000, 32'h5,      4'hF, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 32'h0000_000C, 32'h0,      4'hF, 1'b0, 32'h0};
    vecs[15] = '{1'b1, 32'h0000_0004, 32'h1014,   4'hF, 1'b0, 32'h0};
    vecs[16] = '{1'b1, 32'h0000_0000, 32'h5,      4'hF, 1'b1, 32'h0};
    vecs[17] = '{1'b1, 32'h0000_0004, 32'h1000,   4'hF, 1'b0, 32'h0};
    vecs[18] = '{1'b0, 32'h0000_0004, 32'h0,      4'hF, 1'b0, 32'h1000};
    vecs[19] = '{1'b0, 32'h0000_000C, 32'h0,      4'hF, 1'b0, 32'h0};

    repeat (2) @(negedge clk_i);
    check_outputs_zero("initial_reset");
    rst_i = 1'b0;

    // register map and error table
    for (int i = 0; i < 20; i++) begin
      dev_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er);
      check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
    check("exit_after_bad_halts", exit_code_o, 32'd0);
    check("idle_no_req", {31'd0, host_req_o}, 32'd0);

    // basic dump 0x1000..0x1010, 1-cycle latency
    lat = 1;
    clear_logs();
    dev_access(1'b1, 32'h000, 32'h5, 4'hF, rd, er);
    check("halt_err", {31'd0, er}, 32'd0);
    check("req_after_halt", {31'd0, host_req_o}, 32'd1);
    dev_access(1'b1, 32'h000, 32'h6, 4'hF, rd, er);
    check("halt_busy_err", {31'd0, er}, 32'd1);
    dev_access(1'b1, 32'h004, 32'h5000, 4'hF, rd, er);
    check("begin_busy_err", {31'd0, er}, 32'd1);
    wait_done(100);
    check("basic_grants", grant_addr_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < grant_addr_q.size(); i++)
      check("basic_addr", grant_addr_q[i], 32'h1000 + 32'(4 * i));
    if (grant_cyc_q.size() == 4)
      check("back_to_back_grants", grant_cyc_q[3] - grant_cyc_q[0], 32'd3);
    check_words("basic", 4, 32'h1000);
    if (sig_cyc_q.size() > 0)
      check("done_after_last_sig", done_cyc, sig_cyc_q[sig_cyc_q.size() - 1] + 1);
    check("basic_exit", exit_code_o, 32'h5);
    dev_access(1'b0, 32'h004, 32'h0, 4'hF, rd, er);
    check("begin_kept", rd, 32'h1000);
    dev_access(1'b0, 32'h00C, 32'h0, 4'hF, rd, er);
    check("basic_status", rd, 32'h0004_0002);
    dev_access(1'b1, 32'h000, 32'h7, 4'hF, rd, er);
    check("halt_in_done_err", {31'd0, er}, 32'd1);
    check("exit_kept", exit_code_o, 32'h5);

    // pipelining, 3-cycle latency, 8 words
    do_reset();
    lat = 3;
    program_region(32'h3000, 32'h3020);
    clear_logs();
    dev_access(1'b1, 32'h000, 32'h7, 4'hF, rd, er);
    check("pipe_halt_err", {31'd0, er}, 32'd0);
    wait_done(200);
    check("pipe_grants", grant_addr_q.size(), 32'd8);
    check("pipe_max_outstanding", mdl_max, 32'd2);
    if (grant_cyc_q.size() > 2 && rv_cyc_q.size() > 0)
      check("third_req_held", {31'd0, grant_cyc_q[2] > rv_cyc_q[0]}, 32'd1);
    check_words("pipe", 8, 32'h3000);
    check("pipe_exit", exit_code_o, 32'h7);
    dev_access(1'b0, 32'h00C, 32'h0, 4'hF, rd, er);
    check("pipe_status", rd, 32'h0008_0002);

    // empty region
    do_reset();
    lat = 1;
    program_region(32'h2000, 32'h2000);
    clear_logs();
    dev_access(1'b1, 32'h000, 32'h9, 4'hF, rd, er);
    check("empty_halt_err", {31'd0, er}, 32'd0);
    wait_done(20);
    check("empty_grants", grant_addr_q.size(), 32'd0);
    check("empty_words", sig_data_q.size(), 32'd0);
    dev_access(1'b0, 32'h00C, 32'h0, 4'hF, rd, er);
    check("empty_status", rd, 32'h0000_0002);
    check("empty_exit", exit_code_o, 32'h9);

    // stray response while idle
    do_reset();
    clear_logs();
    @(posedge clk_i); #1; stray = 1'b1;
    @(posedge clk_i); #1; stray = 1'b0;
    repeat (3) @(negedge clk_i);
    check("stray_no_sig", sig_data_q.size(), 32'd0);

    // reset in the middle of a dump, then restart
    lat = 3;
    program_region(32'h3000, 32'h3020);
    clear_logs();
    dev_access(1'b1, 32'h000, 32'h3, 4'hF, rd, er);
    begin
      int k;
      k = 0;
      while (sig_data_q.size() < 2 && k < 100) begin
        @(negedge clk_i);
        k++;
      end
    end
    check("mid_words_seen", {31'd0, sig_data_q.size() >= 2}, 32'd1);
    do_reset();
    dev_access(1'b0, 32'h00C, 32'h0, 4'hF, rd, er);
    check("mid_status_idle", rd, 32'h0);
    clear_logs();
    program_region(32'h3000, 32'h3020);
    check("stale_ignored", sig_data_q.size(), 32'd0);
    dev_access(1'b1, 32'h000, 32'h4, 4'hF, rd, er);
    check("restart_halt_err", {31'd0, er}, 32'd0);
    wait_done(200);
    check_words("restart", 8, 32'h3000);
    check("restart_exit", exit_code_o, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sim_testutil_ctrl.md
# sim_testutil_ctrl

Simulation-only test controller attached to the core's data bus as a device and to the signature memory as a bus host. It is the parametrised successor of the single-outstanding signature dumper. Software programs a signature region and then writes a halt register carrying an exit code. The block streams the region out through a pipelined host port with up to `MaxOutstanding` reads in flight, presents each word on a monitor port, and then asserts `done_o`.

## Interface
- `MaxOutstanding`, default 2: maximum host reads granted but not yet returned (1..15).
- `CountWidth`, default 16: width of the signature word counter.
- `clk_i`, input, 1: clock.
- `rst_i`, input, 1: reset; asynchronous, active-high.
- `dev_req_i`, input, 1: device request; always accepted, no grant.
- `dev_we_i`, input, 1: device write enable.
- `dev_addr_i`, input, 32: device address; only [9:0] decoded, [31:10] ignored.
- `dev_wdata_i`, input, 32: device write data.
- `dev_be_i`, input, 4: device byte enables.
- `dev_rvalid_o`, output, 1: response valid, one cycle after request.
- `dev_rdata_o`, output, 32: read data, registered with `dev_rvalid_o`.
- `dev_err_o`, output, 1: error, registered with `dev_rvalid_o`.
- `host_req_o`, output, 1: host read request.
- `host_gnt_i`, input, 1: host grant.
- `host_addr_o`, output, 32: host read address, word aligned.
- `host_rvalid_i`, input, 1: host read data valid; responses return in order.
- `host_rdata_i`, input, 32: host read data.
- `sig_valid_o`, output, 1: one-cycle strobe per signature word.
- `sig_data_o`, output, 32: signature word.
- `sig_index_o`, output, CountWidth: index of the word, starting at 0.
- `done_o`, output, 1: dump complete; sticky until reset.
- `exit_code_o`, output, 32: exit code latched by the halt write.

## Operation
Device register map, decoded on offset `dev_addr_i[9:0]`:
- 0x000 HALT (write only). A write latches `exit_code_o` from `dev_wdata_i` and starts the dump.
- 0x004 BEGIN (read/write): signature start address.
- 0x008 END (read/write): signature end address, exclusive.
- 0x00C STATUS (read only):
  - bit0: busy.
  - bit1: done.
  - [31:16]: words emitted, zero-extended or truncated from CountWidth.
- Reads of BEGIN and END return the stored value.

`dev_err_o` is set in any of these cases:
- A write with `dev_be_i` not equal to 4'hF.
- Any access to an unmapped offset.
- A write to STATUS, or a read of HALT.
- A write to BEGIN or END while busy.
- A HALT write while not in IDLE.
- A HALT write with BEGIN[1:0] nonzero, END[1:0] nonzero, or END < BEGIN.

An erroring access has no side effect. Its `dev_rdata_o` is 0.

FSM states: IDLE → ISSUE → DRAIN → DONE.
- **IDLE.** A valid HALT write loads `addr_q` = BEGIN and clears the counters. If BEGIN == END the next state is DONE with zero words; otherwise it is ISSUE.
- **ISSUE.**
  - `host_req_o` = 1 when `outstanding_q` < `MaxOutstanding`; `host_addr_o` = `addr_q`.
  - On `host_req_o` && `host_gnt_i`: `addr_q` += 4 (32-bit wrap) and `outstanding_q` += 1.
  - When the granted address + 4 equals END, the next state is DRAIN.
- **DRAIN.** `host_req_o` = 0. When `outstanding_q` reaches 0, the next state is DONE.
- **DONE.** `done_o` = 1 and the state holds until reset. Further HALT writes are ignored and return an error.

Every `host_rvalid_i` received while `outstanding_q` > 0, in ISSUE or DRAIN, produces one output word:
- `sig_valid_o` = 1 with `sig_data_o` = `host_rdata_i` and `sig_index_o` = `count_q`.
- `count_q` and `outstanding_q` then update: `count_q` += 1, `outstanding_q` -= 1.
- `count_q` wraps modulo 2^CountWidth.

Boundary cases:
- A grant and an rvalid in the same cycle leave `outstanding_q` unchanged.
- `host_rvalid_i` with `outstanding_q` == 0, or in IDLE or DONE, is ignored.

## Timing
- Reset values: every output is 0, the state is IDLE, and all registers are 0.
- Reset asserted mid-dump aborts immediately. Responses that arrive after reset is released are ignored.
- Device response: `dev_rvalid_o`, `dev_rdata_o` and `dev_err_o` are driven in the cycle after `dev_req_i`. Back-to-back requests are supported.
- A HALT write in cycle N puts `host_req_o` high from cycle N+1.
- `sig_valid_o` and `sig_data_o` are registered: they appear one cycle after the corresponding `host_rvalid_i`.
- `done_o` rises one cycle after the last `sig_valid_o`.
- With zero wait states and immediate grants, the block issues one request per cycle, capped by `MaxOutstanding`.

## Configuration
- `SIM_TESTUTIL_FINISH_EN`, defined: each signature word is printed as "SIGNATURE: 0x%08x". On entering DONE the block prints the exit code and calls `$finish`.
- Not defined: nothing is printed and the simulation is not terminated; the bench observes `done_o` and `exit_code_o`.
- Register behaviour and port behaviour are identical in both cases.

## Test plan
- **Basic dump.** Set BEGIN=0x1000 and END=0x1010, then write HALT with 0x5; memory always grants with 1-cycle rvalid. Required response:
  - 4 requests at 0x1000, 0x1004, 0x1008, 0x100C.
  - `sig_index_o` 0..3 carrying the memory data.
  - `done_o` = 1 and `exit_code_o` = 0x5.
- **Pipelining.** `MaxOutstanding`=2 with 3-cycle rvalid latency and grants every cycle. The third request stays held until the first rvalid; `outstanding_q` never exceeds 2; 8 words are emitted in order.
- **Empty region.** BEGIN=END=0x2000 followed by a HALT write. Zero host requests; `done_o` asserts; STATUS reads 0x2 in bits [1:0] with count 0.
- **Errors.** Each of the following gets `dev_err_o`=1 and leaves state and registers unchanged:
  - HALT write with BEGIN=0x1002.
  - Write with `dev_be_i`=4'h3.
  - Write to offset 0x010.
  - Second HALT write while busy.
- **Simultaneous events.** Grant and rvalid arrive in the same cycle: `outstanding_q` is unchanged. Stray rvalid while IDLE: no `sig_valid_o`.
- **Reset mid-dump.** Assert `rst_i` after 2 of 8 words: all outputs are 0, the state is IDLE, and a new HALT write restarts the dump from index 0.
